lfsr_seq_checker: RTL and testbench

Receive-side checker for the 14-bit Sierpinski/LFSR pattern generator. It consumes the serial LFSR bit stream looped back on the input pins, self-synchronises a local 14-bit Fibonacci LFSR to it, and declares lock. Once locked, it flags and counts every bit that disagrees with the predicted sequence. It sits beside the generator in the tt_um_sierpinski_lfsr top level as the loopback/bring-up partner.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_sat_counter.sv | 22 ++
 rtl/lfsr_seq_checker.sv | 143 ++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 14-bit Sierpinski/LFSR generator and its receive-side checker.
package lfsr_pkg;

  localparam int LFSR_W = 14;

  // Taps for x^14+x^13+x^12+x^2+1 on a left-shifting register: bits 13, 12, 11, 1.
  localparam logic [LFSR_W-1:0] TAP_MASK = 14'b11_1000_0000_0010;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] sr);
    return ^(sr & TAP_MASK);
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lfsr_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the looped-back 14-bit LFSR stream.
// Error/bit statistics counters are built only when LFSR_CHK_STATS_EN is defined.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 32,
  parameter int LOSS_COUNT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic [1:0]       state,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int FILL_W  = $clog2(LFSR_W + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LFSR_W);

  chk_state_e          st;
  logic [LFSR_W-1:0]   sr;
  logic [FILL_W-1:0]   fill_cnt;
  logic [MATCH_W-1:0]  match_cnt;
  logic [MISS_W-1:0]   miss_cnt;

  logic                bit_vld;
  logic                pred;
  logic                mismatch;
  logic [LFSR_W-1:0]   sr_din;
  logic [LFSR_W-1:0]   sr_pred;
  logic [FILL_W-1:0]   fill_nxt;

  assign bit_vld  = ena && din_valid;
  assign pred     = lfsr_next_bit(sr);
  assign mismatch = din ^ pred;
  assign sr_din   = {sr[LFSR_W-2:0], din};
  assign sr_pred  = {sr[LFSR_W-2:0], pred};
  assign fill_nxt = (fill_cnt == FILL_MAX) ? fill_cnt : fill_cnt + 1'b1;
  assign state    = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= HUNT;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bit_vld) begin
        unique case (st)
          HUNT: begin
            sr       <= sr_din;
            fill_cnt <= fill_nxt;
            // An all-zero register is the LFSR lock-up state, so keep filling.
            if ((fill_nxt == FILL_MAX) && (sr_din != '0)) begin
              st        <= VERIFY;
              match_cnt <= '0;
            end
          end
          VERIFY: begin
            sr <= sr_pred;
            if (!mismatch) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                st       <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              st        <= HUNT;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            sr <= sr_pred;
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (miss_cnt == MISS_W'(LOSS_COUNT - 1)) begin
                st        <= HUNT;
                locked    <= 1'b0;
                fill_cnt  <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            st     <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LFSR_CHK_STATS_EN
  logic bit_inc;
  logic err_inc;
  logic cnt_clr;

  assign bit_inc = bit_vld && (st == LOCKED);
  assign err_inc = bit_inc && mismatch;
  assign cnt_clr = ena && clr_cnt;

  lfsr_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (cnt_clr),
    .count (err_count)
  );

  lfsr_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bit_inc),
    .clr   (cnt_clr),
    .count (bit_count)
  );
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign err_count      = '0;
  assign bit_count      = '0;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed + randomized bench for lfsr_seq_checker against a sequence-level reference model.
module tb_lfsr_seq_checker;

  localparam int LOCK_COUNT = 32;
  localparam int LOSS_COUNT = 8;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef LFSR_CHK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [1:0]       state;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  lfsr_seq_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_COUNT (LOSS_COUNT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .state     (state),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference stream source and checker model, both as bit histories (oldest first).
  bit gen_q[$];
  bit hist[$];
  int m_state, m_fill, m_match, m_miss, m_err, m_bits;
  bit m_pulse;

  // Recurrence b[n] = b[n-14]^b[n-13]^b[n-12]^b[n-2] of x^14+x^13+x^12+x^2+1.
  function automatic bit rec_bit(input bit q[$]);
    return q[$-13] ^ q[$-12] ^ q[$-11] ^ q[$-1];
  endfunction

  function automatic bit last14_nonzero(input bit q[$]);
    for (int i = 0; i < 14; i++) if (q[q.size()-1-i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int cnt_exp(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic gen_seed();
    gen_q.delete();
    for (int i = 0; i < 13; i++) gen_q.push_back(1'b0);
    gen_q.push_back(1'b1);
  endtask

  task automatic gen_next(output bit b);
    b = rec_bit(gen_q);
    gen_q.push_back(b);
    if (gen_q.size() > 20) void'(gen_q.pop_front());
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 14; i++) hist.push_back(1'b0);
    m_state = 0; m_fill = 0; m_match = 0; m_miss = 0;
    m_err = 0; m_bits = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit d, input bit v, input bit e, input bit c);
    bit p;
    m_pulse = 1'b0;
    if (e && v) begin
      case (m_state)
        0: begin
          hist.push_back(d);
          if (m_fill < 14) m_fill++;
          if (m_fill == 14 && last14_nonzero(hist)) begin
            m_state = 1; m_match = 0;
          end
        end
        1: begin
          p = rec_bit(hist);
          hist.push_back(p);
          if (d == p) begin
            m_match++;
            if (m_match == LOCK_COUNT) begin m_state = 2; m_miss = 0; end
          end else begin
            m_state = 0; m_fill = 0; m_match = 0;
          end
        end
        default: begin
          p = rec_bit(hist);
          hist.push_back(p);
          if (m_bits < CNT_MAX) m_bits++;
          if (d != p) begin
            m_pulse = 1'b1;
            if (m_err < CNT_MAX) m_err++;
            m_miss++;
            if (m_miss == LOSS_COUNT) begin
              m_state = 0; m_fill = 0; m_match = 0; m_miss = 0;
            end
          end else begin
            m_miss = 0;
          end
        end
      endcase
      if (hist.size() > 20) void'(hist.pop_front());
    end
    if (e && c) begin m_err = 0; m_bits = 0; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("state", 32'(state), m_state);
    chk("locked", 32'(locked), 32'(m_state == 2));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_count", 32'(err_count), cnt_exp(m_err));
    chk("bit_count", 32'(bit_count), cnt_exp(m_bits));
  endtask

  task automatic step(input bit d, input bit v, input bit e, input bit c);
    din = d; din_valid = v; ena = e; clr_cnt = c;
    @(posedge clk);
    model_step(d, v, e, c);
    #1;
    check_all();
  endtask

  // Sends the next stream bit (optionally inverted) when it will be consumed.
  task automatic send(input bit flip, input bit v, input bit e, input bit c);
    bit b;
    if (e && v) begin
      gen_next(b);
      b = b ^ flip;
    end else begin
      b = 1'($urandom);
    end
    step(b, v, e, c);
  endtask

  task automatic do_reset();
    din_valid = 1'b0; ena = 1'b0; clr_cnt = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    gen_seed();
    chk("rst_state", 32'(state), 0);
    chk("rst_locked", 32'(locked), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nv;
    int cyc;
    bit v, e;

    // Reset state
    do_reset();
    check_all();

    // Lock from reset with a continuous stream
    for (int i = 0; i < 14; i++) send(1'b0, 1'b1, 1'b1, 1'b0);
    chk("hunt_to_verify", 32'(state), 1);
    for (int i = 0; i < LOCK_COUNT; i++) send(1'b0, 1'b1, 1'b1, 1'b0);
    chk("verify_to_locked", 32'(state), 2);
    chk("lock_err_count", 32'(err_count), 0);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1, 1'b1, 1'b0);

    // Single error
    send(1'b1, 1'b1, 1'b1, 1'b0);
    chk("single_pulse", 32'(err_pulse), 1);
    chk("single_err_count", 32'(err_count), cnt_exp(1));
    send(1'b0, 1'b1, 1'b1, 1'b0);
    chk("single_pulse_end", 32'(err_pulse), 0);
    chk("single_still_locked", 32'(locked), 1);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1, 1'b1, 1'b0);

    // Loss of lock and relock
    for (int i = 0; i < LOSS_COUNT; i++) begin
      send(1'b1, 1'b1, 1'b1, 1'b0);
      chk("loss_pulse", 32'(err_pulse), 1);
    end
    chk("loss_state", 32'(state), 0);
    chk("loss_locked", 32'(locked), 0);
    for (int i = 0; i < 14 + LOCK_COUNT - 1; i++) send(1'b0, 1'b1, 1'b1, 1'b0);
    chk("relock_not_yet", 32'(locked), 0);
    send(1'b0, 1'b1, 1'b1, 1'b0);
    chk("relock", 32'(locked), 1);

    // clr_cnt together with a mismatch
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_err_count", 32'(err_count), 0);
    chk("clr_pulse", 32'(err_pulse), 1);
    chk("clr_bit_count", 32'(bit_count), 0);

    // Saturation of err_count with 20 isolated errors
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b1, 1'b0);
    end
    chk("sat_err_count", 32'(err_count), cnt_exp(CNT_MAX));
    chk("sat_locked", 32'(locked), 1);

    // Asynchronous reset while locked
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_locked", 32'(locked), 0);
    chk("async_rst_pulse", 32'(err_pulse), 0);
    chk("async_rst_err", 32'(err_count), 0);
    chk("async_rst_bits", 32'(bit_count), 0);
    do_reset();

    // All-zero input never leaves HUNT
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("zero_state", 32'(state), 0);

    // Randomly stalled stream: lock after exactly 46 consumed bits
    do_reset();
    nv = 0;
    cyc = 0;
    while (nv < 14 + LOCK_COUNT && cyc < 2000) begin
      v = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 9) != 0);
      if (v && e) nv++;
      send(1'b0, v, e, 1'b0);
      cyc++;
    end
    chk("stall_lock_budget", 32'(nv), 14 + LOCK_COUNT);
    chk("stall_locked", 32'(locked), 1);

    // Random errors, stalls and clears, all tracked by the model
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 9) != 0);
      send(($urandom_range(0, 15) == 0), v, e, ($urandom_range(0, 31) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
